conv_sequencer: RTL and testbench

Command-driven controller that sequences the 3x3 convolution datapath (Conv, Fsmv, three line BRAMs) in place of per-bit GPIO toggling by the soft processor. The processor issues one-word commands over a valid/ready handshake. The block then generates all of the datapath control strobes: kernel load, column writes into the three BRAMs, run start, end-of-pass detection, and result readback from BRAM 0. It sits between the GPIO bridge and the convolution top level.

---
 rtl/conv_sequencer_if.sv | 23 ++
 rtl/conv_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - command/response handshake bundle between the processor bridge and conv_sequencer
interface conv_sequencer_if #(
  parameter int BIT_LEN   = 8,
  parameter int RAM_WIDTH = 13
);
  logic                 cmdValid;
  logic                 cmdReady;
  logic [2:0]           cmdOp;
  logic [3*BIT_LEN-1:0] cmdData;
  logic                 rspValid;
  logic                 rspReady;
  logic [RAM_WIDTH-1:0] rspData;

  modport master (
    output cmdValid, cmdOp, cmdData, rspReady,
    input  cmdReady, rspValid, rspData
  );

  modport slave (
    input  cmdValid, cmdOp, cmdData, rspReady,
    output cmdReady, rspValid, rspData
  );
endinterface

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - command-driven sequencer for the 3x3 convolution datapath
// Turns one-word processor commands into Conv/Fsmv/BRAM control strobes; every output is registered.
module conv_sequencer #(
  parameter int BIT_LEN   = 8,
  parameter int RAM_WIDTH = 13,
  parameter int NB_IMAGE  = 10
) (
  input  logic                 i_CLK,
  input  logic                 i_reset,
  conv_sequencer_if.slave      bus,
  output logic                 o_rstConv,
  output logic                 o_rstFsm,
  output logic                 o_kI,
  output logic [BIT_LEN-1:0]   o_kData0,
  output logic [BIT_LEN-1:0]   o_kData1,
  output logic [BIT_LEN-1:0]   o_kData2,
  output logic                 o_kStrobe,
  output logic [1:0]           o_sel,
  output logic [RAM_WIDTH-1:0] o_memData,
  output logic                 o_sop,
  output logic                 o_validFsm,
  output logic                 o_load,
  output logic [NB_IMAGE-1:0]  o_imgLength,
  input  logic                 i_EoP,
  input  logic [RAM_WIDTH-1:0] i_mem0Data,
  output logic                 o_done,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_KLOAD, S_COLW, S_START, S_RUN, S_RDWAIT, S_RSP
  } state_t;

  localparam logic [2:0] OP_SET_LEN  = 3'd1;
  localparam logic [2:0] OP_LOAD_K   = 3'd2;
  localparam logic [2:0] OP_LOAD_COL = 3'd3;
  localparam logic [2:0] OP_RUN      = 3'd4;
  localparam logic [2:0] OP_READ     = 3'd5;
  localparam logic [2:0] OP_CLR      = 3'd6;

  state_t               state_q;
  logic [1:0]           kcnt_q, kcnt_d;
  logic [1:0]           colptr_q, colptr_d;
  logic                 phase_q;
  logic                 ready_q;
  logic                 rstconv_q, rstfsm_q, ki_q, kstrobe_q;
  logic [BIT_LEN-1:0]   kdata0_q, kdata1_q, kdata2_q;
  logic [1:0]           sel_q;
  logic [RAM_WIDTH-1:0] memdata_q;
  logic                 sop_q, validfsm_q, load_q, done_q, err_q;
  logic [NB_IMAGE-1:0]  imglen_q;
  logic                 rspvalid_q;
  logic [RAM_WIDTH-1:0] rspdata_q;
  logic                 cmd_fire;
  logic                 run_ok;

  // A fourth kernel word starts a fresh kernel at slot 1 rather than 0.
  assign kcnt_d   = (kcnt_q == 2'd3) ? 2'd1 : kcnt_q + 2'd1;
  assign colptr_d = (colptr_q == 2'd2) ? 2'd0 : colptr_q + 2'd1;
  assign cmd_fire = bus.cmdValid & ready_q;
  assign run_ok   = (kcnt_q == 2'd3) && (colptr_q == 2'd0);

  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      kcnt_q     <= 2'd0;
      colptr_q   <= 2'd0;
      phase_q    <= 1'b0;
      ready_q    <= 1'b1;
      rstconv_q  <= 1'b0;
      rstfsm_q   <= 1'b0;
      ki_q       <= 1'b0;
      kstrobe_q  <= 1'b0;
      kdata0_q   <= '0;
      kdata1_q   <= '0;
      kdata2_q   <= '0;
      sel_q      <= 2'b00;
      memdata_q  <= '0;
      sop_q      <= 1'b0;
      validfsm_q <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      imglen_q   <= NB_IMAGE'(10);
      rspvalid_q <= 1'b0;
      rspdata_q  <= '0;
    end else begin
      rstconv_q  <= 1'b0;
      rstfsm_q   <= 1'b0;
      ki_q       <= 1'b0;
      kstrobe_q  <= 1'b0;
      sel_q      <= 2'b00;
      sop_q      <= 1'b0;
      validfsm_q <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Every accepted command costs at least one busy cycle, even those that stay in IDLE.
          ready_q <= 1'b1;
          if (cmd_fire) begin
            ready_q <= 1'b0;
            case (bus.cmdOp)
              OP_SET_LEN: begin
                imglen_q <= bus.cmdData[NB_IMAGE-1:0];
                rstfsm_q <= 1'b1;
              end
              OP_LOAD_K: begin
                state_q   <= S_KLOAD;
                kstrobe_q <= 1'b1;
                kdata0_q  <= bus.cmdData[BIT_LEN-1:0];
                kdata1_q  <= bus.cmdData[2*BIT_LEN-1:BIT_LEN];
                kdata2_q  <= bus.cmdData[3*BIT_LEN-1:2*BIT_LEN];
                kcnt_q    <= kcnt_d;
              end
              OP_LOAD_COL: begin
                state_q    <= S_COLW;
                sel_q      <= colptr_q + 2'd1;
                memdata_q  <= bus.cmdData[RAM_WIDTH-1:0];
                load_q     <= 1'b1;
                validfsm_q <= 1'b1;
                colptr_q   <= colptr_d;
              end
              OP_RUN: begin
                if (!run_ok) begin
                  err_q <= 1'b1;
                end else begin
                  state_q    <= S_START;
                  ki_q       <= 1'b1;
                  sop_q      <= 1'b1;
                  validfsm_q <= 1'b1;
                end
              end
              OP_READ: begin
                state_q    <= S_RDWAIT;
                validfsm_q <= 1'b1;
                phase_q    <= 1'b0;
              end
              OP_CLR: begin
                state_q   <= S_CLR;
                rstconv_q <= 1'b1;
                rstfsm_q  <= 1'b1;
                phase_q   <= 1'b0;
                kcnt_q    <= 2'd0;
                colptr_q  <= 2'd0;
                err_q     <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        S_KLOAD, S_COLW: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        S_START: begin
          state_q    <= S_RUN;
          ki_q       <= 1'b1;
          validfsm_q <= 1'b1;
        end

        S_RUN: begin
          if (i_EoP) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            ki_q       <= 1'b1;
            validfsm_q <= 1'b1;
          end
        end

        // First cycle drives the Fsmv read strobe, second covers the BRAM read latency.
        S_RDWAIT: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            state_q    <= S_RSP;
            rspdata_q  <= i_mem0Data;
            rspvalid_q <= 1'b1;
          end
        end

        S_RSP: begin
          if (bus.rspReady) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            rspvalid_q <= 1'b0;
          end
        end

        S_CLR: begin
          if (!phase_q) begin
            phase_q   <= 1'b1;
            rstconv_q <= 1'b1;
            rstfsm_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmdReady = ready_q;
  assign bus.rspValid = rspvalid_q;
  assign bus.rspData  = rspdata_q;
  assign o_rstConv    = rstconv_q;
  assign o_rstFsm     = rstfsm_q;
  assign o_kI         = ki_q;
  assign o_kData0     = kdata0_q;
  assign o_kData1     = kdata1_q;
  assign o_kData2     = kdata2_q;
  assign o_kStrobe    = kstrobe_q;
  assign o_sel        = sel_q;
  assign o_memData    = memdata_q;
  assign o_sop        = sop_q;
  assign o_validFsm   = validfsm_q;
  assign o_load       = load_q;
  assign o_imgLength  = imglen_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - self-checking bench for conv_sequencer against a command-level model
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if #(.BIT_LEN(8), .RAM_WIDTH(13)) bus ();

  logic        o_rstConv, o_rstFsm, o_kI, o_kStrobe, o_sop, o_validFsm, o_load, o_done, o_err;
  logic [7:0]  o_kData0, o_kData1, o_kData2;
  logic [1:0]  o_sel;
  logic [12:0] o_memData;
  logic [9:0]  o_imgLength;
  logic        i_EoP;
  logic [12:0] i_mem0Data;

  conv_sequencer #(.BIT_LEN(8), .RAM_WIDTH(13), .NB_IMAGE(10)) dut (
    .i_CLK       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_rstConv   (o_rstConv),
    .o_rstFsm    (o_rstFsm),
    .o_kI        (o_kI),
    .o_kData0    (o_kData0),
    .o_kData1    (o_kData1),
    .o_kData2    (o_kData2),
    .o_kStrobe   (o_kStrobe),
    .o_sel       (o_sel),
    .o_memData   (o_memData),
    .o_sop       (o_sop),
    .o_validFsm  (o_validFsm),
    .o_load      (o_load),
    .o_imgLength (o_imgLength),
    .i_EoP       (i_EoP),
    .i_mem0Data  (i_mem0Data),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  int total = 0;
  int bad   = 0;
  int waited;

  // Command-level model of the architectural state.
  int m_kcnt, m_colptr, m_len;
  bit m_err;

  task automatic model_reset();
    m_kcnt = 0; m_colptr = 0; m_len = 10; m_err = 0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [23:0] d);
    case (op)
      3'd1: m_len = int'(d[9:0]);
      3'd2: m_kcnt = (m_kcnt == 3) ? 1 : m_kcnt + 1;
      3'd3: m_colptr = (m_colptr + 1) % 3;
      3'd4: if (m_kcnt != 3 || m_colptr != 0) m_err = 1;
      3'd6: begin m_kcnt = 0; m_colptr = 0; m_err = 0; end
      default: ;
    endcase
  endtask

  // Holds the command until accepted; returns one cycle after the accepting edge (cycle N+1).
  task automatic issue(input logic [2:0] op, input logic [23:0] d);
    int n = 0;
    bus.cmdValid = 1'b1; bus.cmdOp = op; bus.cmdData = d;
    while (bus.cmdReady !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus.cmdReady !== 1'b1) begin
      bad++; $display("FAIL accept_timeout op=%0d ready=%b required=1", op, bus.cmdReady);
    end
    waited = n;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    model_cmd(op, d);
  endtask

  task automatic test_reset();
    logic [9:0] fl;
    rst = 1'b1; bus.cmdValid = 0; bus.cmdOp = 0; bus.cmdData = 0; bus.rspReady = 0;
    i_EoP = 0; i_mem0Data = 0;
    repeat (3) @(posedge clk);
    #1;
    fl = {o_rstConv, o_rstFsm, o_kStrobe, o_sop, o_validFsm, o_load, o_done, o_err, bus.rspValid, o_kI};
    total++; if (fl !== 10'd0) begin bad++; $display("FAIL reset_flags got=%b required=0", fl); end
    total++; if (bus.cmdReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", bus.cmdReady); end
    total++; if (o_imgLength !== 10'd10) begin bad++; $display("FAIL reset_len got=%0d required=10", o_imgLength); end
    total++;
    if (o_sel !== 2'b00 || o_memData !== 13'd0 || {o_kData2, o_kData1, o_kData0} !== 24'd0 || bus.rspData !== 13'd0) begin
      bad++; $display("FAIL reset_data sel=%b mem=%h k=%h rsp=%h required=0", o_sel, o_memData,
                      {o_kData2, o_kData1, o_kData0}, bus.rspData);
    end
    @(posedge clk); #1; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_set_len();
    logic [23:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom);
      issue(3'd1, d);
      total++;
      if (o_imgLength !== 10'(m_len) || o_rstFsm !== 1'b1 || bus.cmdReady !== 1'b0) begin
        bad++; $display("FAIL set_len len=%0d rstFsm=%b ready=%b required len=%0d rstFsm=1 ready=0",
                        o_imgLength, o_rstFsm, bus.cmdReady, m_len);
      end
      @(posedge clk); #1;
      total++;
      if (o_rstFsm !== 1'b0 || bus.cmdReady !== 1'b1) begin
        bad++; $display("FAIL set_len_after rstFsm=%b ready=%b required 0/1", o_rstFsm, bus.cmdReady);
      end
    end
  endtask

  task automatic test_load_k();
    logic [23:0] words [4];
    words[0] = 24'h030201; words[1] = 24'h060504; words[2] = 24'h090807; words[3] = 24'($urandom);
    for (int i = 0; i < 4; i++) begin
      issue(3'd2, words[i]);
      total++;
      if (o_kStrobe !== 1'b1 || o_kI !== 1'b0 || {o_kData2, o_kData1, o_kData0} !== words[i]) begin
        bad++; $display("FAIL load_k%0d strobe=%b kI=%b k=%h required strobe=1 kI=0 k=%h",
                        i, o_kStrobe, o_kI, {o_kData2, o_kData1, o_kData0}, words[i]);
      end
      @(posedge clk); #1;
      total++;
      if (o_kStrobe !== 1'b0 || bus.cmdReady !== 1'b1) begin
        bad++; $display("FAIL load_k_after strobe=%b ready=%b required 0/1", o_kStrobe, bus.cmdReady);
      end
    end
  endtask

  task automatic test_load_col();
    logic [1:0] esel;
    for (int i = 1; i <= 6; i++) begin
      esel = 2'(m_colptr + 1);
      issue(3'd3, 24'(i));
      total++;
      if (o_sel !== esel || o_load !== 1'b1 || o_validFsm !== 1'b1 || o_memData !== 13'(i)) begin
        bad++; $display("FAIL load_col%0d sel=%b load=%b vf=%b mem=%0d required sel=%b load=1 vf=1 mem=%0d",
                        i, o_sel, o_load, o_validFsm, o_memData, esel, i);
      end
      @(posedge clk); #1;
      total++;
      if (o_load !== 1'b0 || o_validFsm !== 1'b0 || bus.cmdReady !== 1'b1) begin
        bad++; $display("FAIL load_col_after load=%b vf=%b ready=%b required 0/0/1", o_load, o_validFsm, bus.cmdReady);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    logic [1:0]  esel;
    issue(3'd3, 24'h000111);
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom);
      esel = 2'(m_colptr + 1);
      issue(i == 2 ? 3'd2 : 3'd3, d);
      total++;
      if (waited !== 1) begin bad++; $display("FAIL b2b_spacing%0d got=%0d required=1", i, waited); end
      if (i < 2) begin
        total++;
        if (o_sel !== esel || o_memData !== d[12:0]) begin
          bad++; $display("FAIL b2b_col%0d sel=%b mem=%h required sel=%b mem=%h", i, o_sel, o_memData, esel, d[12:0]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_run();
    int lens [3];
    int vcnt;
    bit early_done;
    lens[0] = 20; lens[1] = int'($urandom_range(1, 12)); lens[2] = int'($urandom_range(2, 30));
    while (m_kcnt != 3) issue(3'd2, 24'($urandom));
    while (m_colptr != 0) issue(3'd3, 24'($urandom));
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      issue(3'd4, 24'd0);
      total++;
      if (o_sop !== 1'b1 || o_validFsm !== 1'b1 || o_kI !== 1'b1 || o_sel !== 2'b00 || o_err !== 1'b0) begin
        bad++; $display("FAIL run_start%0d sop=%b vf=%b kI=%b sel=%b err=%b required 1/1/1/00/0",
                        r, o_sop, o_validFsm, o_kI, o_sel, o_err);
      end
      i_EoP = (r == 2);
      vcnt = (o_validFsm === 1'b1) ? 1 : 0;
      early_done = 0;
      for (int c = 1; c <= lens[r]; c++) begin
        @(posedge clk); #1;
        i_EoP = (c == lens[r]);
        if (o_validFsm === 1'b1) vcnt++;
        if (o_done !== 1'b0 || o_sop !== 1'b0) early_done = 1;
      end
      total++;
      if (early_done) begin bad++; $display("FAIL run_early%0d done/sop seen before end required none", r); end
      total++;
      if (vcnt !== lens[r] + 1) begin bad++; $display("FAIL run_valid%0d got=%0d required=%0d", r, vcnt, lens[r] + 1); end
      @(posedge clk); #1;
      i_EoP = 1'b0;
      total++;
      if (o_done !== 1'b1 || o_validFsm !== 1'b0) begin
        bad++; $display("FAIL run_done%0d done=%b vf=%b required 1/0", r, o_done, o_validFsm);
      end
      @(posedge clk); #1;
      total++;
      if (o_done !== 1'b0 || bus.cmdReady !== 1'b1) begin
        bad++; $display("FAIL run_after%0d done=%b ready=%b required 0/1", r, o_done, bus.cmdReady);
      end
    end
  endtask

  task automatic test_run_err();
    issue(3'd6, 24'd0);
    @(posedge clk); #1;
    issue(3'd2, 24'h112233);
    issue(3'd2, 24'h445566);
    issue(3'd4, 24'd0);
    total++;
    if (o_err !== 1'b1 || o_sop !== 1'b0 || o_validFsm !== 1'b0) begin
      bad++; $display("FAIL run_err err=%b sop=%b vf=%b required 1/0/0", o_err, o_sop, o_validFsm);
    end
    issue(3'd3, 24'h000777);
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required=1", o_err); end
    issue(3'd6, 24'd0);
    total++;
    if (o_rstConv !== 1'b1 || o_rstFsm !== 1'b1 || o_err !== 1'b0) begin
      bad++; $display("FAIL clr_c1 rc=%b rf=%b err=%b required 1/1/0", o_rstConv, o_rstFsm, o_err);
    end
    @(posedge clk); #1;
    total++;
    if (o_rstConv !== 1'b1 || o_rstFsm !== 1'b1 || bus.cmdReady !== 1'b0) begin
      bad++; $display("FAIL clr_c2 rc=%b rf=%b ready=%b required 1/1/0", o_rstConv, o_rstFsm, bus.cmdReady);
    end
    @(posedge clk); #1;
    total++;
    if (o_rstConv !== 1'b0 || o_rstFsm !== 1'b0 || bus.cmdReady !== 1'b1) begin
      bad++; $display("FAIL clr_c3 rc=%b rf=%b ready=%b required 0/0/1", o_rstConv, o_rstFsm, bus.cmdReady);
    end
    issue(3'd4, 24'd0);
    total++;
    if (o_err !== 1'b1 || o_sop !== 1'b0) begin
      bad++; $display("FAIL run_after_clr err=%b sop=%b required 1/0", o_err, o_sop);
    end
    issue(3'd6, 24'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    logic [12:0] vals [2];
    int holds [2];
    bit held;
    vals[0] = 13'h1ABC; vals[1] = 13'($urandom); holds[0] = 5; holds[1] = 0;
    for (int r = 0; r < 2; r++) begin
      i_mem0Data = vals[r];
      bus.rspReady = (holds[r] == 0);
      issue(3'd5, 24'd0);
      total++;
      if (o_validFsm !== 1'b1 || bus.rspValid !== 1'b0) begin
        bad++; $display("FAIL read_c1_%0d vf=%b rv=%b required 1/0", r, o_validFsm, bus.rspValid);
      end
      @(posedge clk); #1;
      total++;
      if (o_validFsm !== 1'b0 || bus.rspValid !== 1'b0) begin
        bad++; $display("FAIL read_c2_%0d vf=%b rv=%b required 0/0", r, o_validFsm, bus.rspValid);
      end
      @(posedge clk); #1;
      total++;
      if (bus.rspValid !== 1'b1 || bus.rspData !== vals[r]) begin
        bad++; $display("FAIL read_rsp%0d rv=%b data=%h required 1/%h", r, bus.rspValid, bus.rspData, vals[r]);
      end
      held = 1;
      for (int c = 0; c < holds[r]; c++) begin
        @(posedge clk); #1;
        if (bus.rspValid !== 1'b1 || bus.rspData !== vals[r] || bus.cmdReady !== 1'b0) held = 0;
      end
      total++;
      if (!held) begin bad++; $display("FAIL read_hold%0d response not held while rspReady low", r); end
      bus.rspReady = 1'b1;
      @(posedge clk); #1;
      bus.rspReady = 1'b0;
      total++;
      if (bus.rspValid !== 1'b0 || bus.cmdReady !== 1'b1) begin
        bad++; $display("FAIL read_end%0d rv=%b ready=%b required 0/1", r, bus.rspValid, bus.cmdReady);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    while (m_kcnt != 3) issue(3'd2, 24'($urandom));
    while (m_colptr != 0) issue(3'd3, 24'($urandom));
    issue(3'd1, 24'd333);
    issue(3'd4, 24'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (o_validFsm !== 1'b0 || o_kI !== 1'b0 || bus.cmdReady !== 1'b1 || o_imgLength !== 10'd10) begin
      bad++; $display("FAIL midrun_reset vf=%b kI=%b ready=%b len=%0d required 0/0/1/10",
                      o_validFsm, o_kI, bus.cmdReady, o_imgLength);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_EoP = 1'b1;
    saw_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0) saw_done = 1;
    end
    i_EoP = 1'b0;
    total++;
    if (saw_done) begin bad++; $display("FAIL midrun_done done pulsed after reset required none"); end
    issue(3'd4, 24'd0);
    total++;
    if (o_err !== 1'b1 || o_sop !== 1'b0) begin
      bad++; $display("FAIL midrun_state err=%b sop=%b required 1/0", o_err, o_sop);
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    logic [2:0]  op;
    logic [1:0]  esel;
    bit          ok_run, exp_err;
    int          len;
    for (int it = 0; it < 60; it++) begin
      d = 24'($urandom);
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5) op = 3'd3;
      esel = 2'(m_colptr + 1);
      ok_run = (m_kcnt == 3 && m_colptr == 0);
      exp_err = m_err;
      issue(op, d);
      total++;
      case (op)
        3'd1: if (o_imgLength !== d[9:0] || o_rstFsm !== 1'b1) begin
          bad++; $display("FAIL rnd_len%0d got=%0d required=%0d", it, o_imgLength, d[9:0]);
        end
        3'd2: if (o_kStrobe !== 1'b1 || {o_kData2, o_kData1, o_kData0} !== d) begin
          bad++; $display("FAIL rnd_k%0d strobe=%b k=%h required 1/%h", it, o_kStrobe, {o_kData2, o_kData1, o_kData0}, d);
        end
        3'd3: if (o_sel !== esel || o_memData !== d[12:0] || o_load !== 1'b1) begin
          bad++; $display("FAIL rnd_col%0d sel=%b mem=%h required %b/%h", it, o_sel, o_memData, esel, d[12:0]);
        end
        3'd4: begin
          if (ok_run) begin
            if (o_sop !== 1'b1) begin bad++; $display("FAIL rnd_run%0d sop=%b required 1", it, o_sop); end
            len = int'($urandom_range(1, 8));
            for (int c = 1; c <= len; c++) begin
              @(posedge clk); #1;
              i_EoP = (c == len);
            end
            @(posedge clk); #1;
            i_EoP = 1'b0;
            total++;
            if (o_done !== 1'b1) begin bad++; $display("FAIL rnd_done%0d got=%b required 1", it, o_done); end
          end else if (o_err !== 1'b1 || o_sop !== 1'b0) begin
            bad++; $display("FAIL rnd_runerr%0d err=%b sop=%b required 1/0", it, o_err, o_sop);
          end
        end
        3'd6: if (o_rstConv !== 1'b1 || o_rstFsm !== 1'b1 || o_err !== 1'b0) begin
          bad++; $display("FAIL rnd_clr%0d rc=%b rf=%b err=%b required 1/1/0", it, o_rstConv, o_rstFsm, o_err);
        end
        default: if ((o_kStrobe | o_load | o_sop | o_rstConv | o_rstFsm) !== 1'b0 || o_err !== exp_err) begin
          bad++; $display("FAIL rnd_nop%0d strobes active or err=%b required err=%b", it, o_err, exp_err);
        end
      endcase
    end
    @(posedge clk); #1;
    total++;
    if (o_err !== m_err || o_imgLength !== 10'(m_len)) begin
      bad++; $display("FAIL rnd_final err=%b len=%0d required %b/%0d", o_err, o_imgLength, m_err, m_len);
    end
  endtask

  initial begin
    test_reset();
    test_set_len();
    test_load_k();
    test_load_col();
    test_back_to_back();
    test_run();
    test_run_err();
    test_read();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
